// File: rtl/stream_bus_bridge_pkg.sv
// Shared register-map constants for the stream-to-bus bridge.
package stream_bus_bridge_pkg;

  // Word addresses of the host register map
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_RSVD    = 2'd3;

  // STATUS bit positions (level occupies the low bits)
  localparam int ST_EMPTY_BIT = 16;
  localparam int ST_FULL_BIT  = 17;
  localparam int ST_OVF_BIT   = 18;
  localparam int ST_UNF_BIT   = 19;
  localparam int ST_IRQ_BIT   = 20;

  // CONTROL bit positions (watermark occupies the low bits)
  localparam int CT_IRQ_EN_BIT = 16;
  localparam int CT_FLUSH_BIT  = 17;

  // STATUS bits that are write-1-to-clear
  localparam logic [31:0] W1C_MASK = 32'h000C_0000;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with level counter and synchronous flush.
// Push is refused when full or flushing; pop is ignored when empty.
module sync_fifo #(
  parameter int DATA_SIZE = 28,
  parameter int DEPTH     = 256,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_SIZE-1:0]  din,
  output logic [DATA_SIZE-1:0]  dout,
  output logic [ADDR_WIDTH:0]   level,
  output logic [ADDR_WIDTH:0]   level_next,
  output logic                  full,
  output logic                  empty
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_SIZE-1:0]  mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Occupancy after this edge; flush overrides any concurrent push/pop
  always_comb begin
    level_next = level;
    if (flush) begin
      level_next = '0;
    end else begin
      level_next = level + LW'(push_ok) - LW'(pop_ok);
    end
  end

  // Pointer and level state; pointers wrap naturally modulo DEPTH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      level <= level_next;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Sample storage carries data only, so it has no reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/stream_bus_bridge.sv
// Stream-to-bus bridge: buffers producer samples and exposes them to the
// host through DATA/STATUS/CONTROL registers, with sticky error flags,
// watermark interrupt and software flush.
module stream_bus_bridge
  import stream_bus_bridge_pkg::*;
#(
  parameter int DATA_SIZE = 28,
  parameter int DEPTH     = 256,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  chipselect,
  input  logic [1:0]            address,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           writedata,
  output logic [31:0]           read_data,
  input  logic                  source_valid,
  input  logic [DATA_SIZE-1:0]  source_data,
  output logic                  source_ready,
  output logic                  irq
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [LW-1:0] WM_RESET = LW'(DEPTH / 2);

  if (DATA_SIZE < 1 || DATA_SIZE > 32) begin : g_bad_data_size
    $error("stream_bus_bridge: DATA_SIZE must be in 1..32");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("stream_bus_bridge: DEPTH must be a power of two and at least 4");
  end

  logic                 rd_strobe, wr_strobe, pop_req;
  logic                 status_wr, control_wr, flush;
  logic                 overflow_evt, underflow_evt;
  logic [DATA_SIZE-1:0] fifo_dout;
  logic [LW-1:0]        level, level_next;
  logic                 full, empty;
  logic                 overflow, underflow, irq_en;
  logic [LW-1:0]        watermark;
  logic                 overflow_next, underflow_next, irq_en_next, irq_next;
  logic [LW-1:0]        watermark_next;
  logic [31:0]          w1c_clr, status_word, control_word, read_data_next;
  logic                 unused_wdata;

  // A read strobe always wins over a write strobe in the same cycle
  assign rd_strobe     = chipselect && read;
  assign wr_strobe     = chipselect && write && !read;
  assign pop_req       = rd_strobe && (address == ADDR_DATA);
  assign status_wr     = wr_strobe && (address == ADDR_STATUS);
  assign control_wr    = wr_strobe && (address == ADDR_CONTROL);
  assign flush         = control_wr && writedata[CT_FLUSH_BIT];
  assign overflow_evt  = source_valid && full && !flush;
  assign underflow_evt = pop_req && empty;
  assign source_ready  = !full;
  assign unused_wdata  = ^writedata;

  sync_fifo #(
    .DATA_SIZE (DATA_SIZE),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (source_valid),
    .pop        (pop_req),
    .flush      (flush),
    .din        (source_data),
    .dout       (fifo_dout),
    .level      (level),
    .level_next (level_next),
    .full       (full),
    .empty      (empty)
  );

  // Readable register images built from current registered state
  always_comb begin
    status_word                = '0;
    status_word[LW-1:0]        = level;
    status_word[ST_EMPTY_BIT]  = empty;
    status_word[ST_FULL_BIT]   = full;
    status_word[ST_OVF_BIT]    = overflow;
    status_word[ST_UNF_BIT]    = underflow;
    status_word[ST_IRQ_BIT]    = irq;
    control_word                = '0;
    control_word[LW-1:0]        = watermark;
    control_word[CT_IRQ_EN_BIT] = irq_en;
  end

  // Next flag/control state; a new event beats a same-cycle W1C clear
  always_comb begin
    w1c_clr        = status_wr ? (writedata & W1C_MASK) : '0;
    overflow_next  = overflow_evt  || (overflow  && !w1c_clr[ST_OVF_BIT]);
    underflow_next = underflow_evt || (underflow && !w1c_clr[ST_UNF_BIT]);
    watermark_next = control_wr ? writedata[LW-1:0] : watermark;
    irq_en_next    = control_wr ? writedata[CT_IRQ_EN_BIT] : irq_en;
    irq_next       = irq_en_next &&
                     (((level_next >= watermark_next) && (watermark_next != '0)) ||
                      overflow_next || underflow_next);
  end

  // Read-data mux; holds the last value when there is no read strobe
  always_comb begin
    read_data_next = read_data;
    if (rd_strobe) begin
      unique case (address)
        ADDR_DATA:    read_data_next = empty ? '0 : 32'(fifo_dout);
        ADDR_STATUS:  read_data_next = status_word;
        ADDR_CONTROL: read_data_next = control_word;
        default:      read_data_next = '0;
      endcase
    end
  end

  // Register stage for bus read data, flags, control and interrupt
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      irq_en    <= 1'b0;
      watermark <= WM_RESET;
      irq       <= 1'b0;
    end else begin
      read_data <= read_data_next;
      overflow  <= overflow_next;
      underflow <= underflow_next;
      irq_en    <= irq_en_next;
      watermark <= watermark_next;
      irq       <= irq_next;
    end
  end

endmodule

// File: tb/tb_stream_bus_bridge.sv
// Scoreboard bench for stream_bus_bridge: a queue-based reference model
// predicts read data, irq and source_ready per clock; a monitor compares.
module tb_stream_bus_bridge;

  localparam int DW    = 12;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           chipselect = 1'b0;
  logic [1:0]     address = 2'd0;
  logic           read = 1'b0;
  logic           write = 1'b0;
  logic [31:0]    writedata = 32'd0;
  logic [31:0]    read_data;
  logic           source_valid = 1'b0;
  logic [DW-1:0]  source_data = '0;
  logic           source_ready;
  logic           irq;

  stream_bus_bridge #(.DATA_SIZE(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .chipselect   (chipselect),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .read_data    (read_data),
    .source_valid (source_valid),
    .source_data  (source_data),
    .source_ready (source_ready),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          edge_n;
    bit          has_rd;
    logic [31:0] rd;
    bit          irq;
    bit          rdy;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  // Reference model state: plain queue of samples plus register fields
  int   mq[$];
  bit   m_ov, m_un, m_en, m_irq;
  int   m_wm;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ov = 0; m_un = 0; m_en = 0; m_irq = 0;
    m_wm = DEPTH / 2;
  endtask

  // Monitor: compare every prediction whose clock edge has already occurred
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].edge_n <= cyc) begin
      e = sb.pop_front();
      if (e.has_rd) chk("read_data", read_data, e.rd);
      chk("irq", 32'(irq), 32'(e.irq));
      chk("source_ready", 32'(source_ready), 32'(e.rdy));
    end
  end

  // Drive one cycle of inputs, predict its outcome, then let the edge pass
  task automatic step(input bit cs, input bit r, input bit w, input logic [1:0] a,
                      input logic [31:0] wd, input bit sv, input logic [DW-1:0] sd);
    exp_t e;
    bit rs, ws, fl, pop_ok, push_ok, ov_e, un_e;
    int sz;
    chipselect = cs; read = r; write = w; address = a;
    writedata = wd; source_valid = sv; source_data = sd;
    rs = cs && r;
    ws = cs && w && !r;
    sz = mq.size();
    fl = ws && (a == 2'd2) && wd[17];
    e.has_rd = rs;
    e.rd = 32'd0;
    if (rs) begin
      case (a)
        2'd0: if (sz > 0) e.rd = 32'(mq[0]);
        2'd1: begin
          e.rd = 32'(sz);
          e.rd[16] = (sz == 0);
          e.rd[17] = (sz == DEPTH);
          e.rd[18] = m_ov;
          e.rd[19] = m_un;
          e.rd[20] = m_irq;
        end
        2'd2: begin
          e.rd = 32'(m_wm);
          e.rd[16] = m_en;
        end
        default: e.rd = 32'd0;
      endcase
    end
    pop_ok  = rs && (a == 2'd0) && (sz > 0);
    un_e    = rs && (a == 2'd0) && (sz == 0);
    push_ok = sv && (sz < DEPTH) && !fl;
    ov_e    = sv && (sz == DEPTH) && !fl;
    if (pop_ok) void'(mq.pop_front());
    if (fl) mq.delete();
    if (push_ok) mq.push_back(int'(sd));
    if (ws && a == 2'd1) begin
      if (wd[18]) m_ov = 0;
      if (wd[19]) m_un = 0;
    end
    if (ov_e) m_ov = 1;
    if (un_e) m_un = 1;
    if (ws && a == 2'd2) begin
      m_wm = int'(wd) & ((1 << (AW + 1)) - 1);
      m_en = wd[16];
    end
    m_irq = m_en && ((mq.size() >= m_wm && m_wm != 0) || m_ov || m_un);
    e.irq = m_irq;
    e.rdy = (mq.size() < DEPTH);
    e.edge_n = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();              step(0, 0, 0, 2'd0, 32'd0, 0, '0); endtask
  task automatic push(input int d);   step(0, 0, 0, 2'd0, 32'd0, 1, DW'(d)); endtask
  task automatic rd_reg(input int a); step(1, 1, 0, 2'(a), 32'd0, 0, '0); endtask
  task automatic wr_reg(input int a, input logic [31:0] d); step(1, 0, 1, 2'(a), d, 0, '0); endtask

  // Reset asserted between clock edges; outputs must clear without an edge
  task automatic async_reset();
    @(negedge clk);
    #2;
    chipselect = 0; read = 0; write = 0; source_valid = 0;
    reset = 1'b1;
    #1;
    chk("async_rst_read_data", read_data, 32'd0);
    chk("async_rst_irq", 32'(irq), 32'd0);
    sb.delete();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    #12;
    chk("reset_read_data", read_data, 32'd0);
    chk("reset_irq", 32'(irq), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 32'(source_ready), 32'd1);

    // Basic push then pop in order
    push(1); push(2); push(3);
    rd_reg(1);
    rd_reg(0); rd_reg(0); rd_reg(0);
    rd_reg(1);

    // Overfill: ready drops at full, extra sample dropped, W1C clear
    for (int i = 0; i < DEPTH + 1; i++) push(16 + i);
    rd_reg(1);
    wr_reg(1, 32'h0004_0000);
    rd_reg(1);
    for (int i = 0; i < DEPTH; i++) rd_reg(0);

    // Underflow alone, then underflow with a same-cycle push
    rd_reg(0);
    step(1, 1, 0, 2'd0, 32'd0, 1, DW'(12'hABC));
    rd_reg(1);
    rd_reg(0);

    // Watermark interrupt rises and falls
    wr_reg(1, 32'h000C_0000);
    wr_reg(2, 32'h0001_0002);
    rd_reg(2);
    push(32'h5A); push(32'h6B);
    idle();
    rd_reg(0);
    idle();

    // Wrapped pointers, then flush alongside a push
    wr_reg(2, 32'h0000_0000);
    for (int i = 0; i < 4; i++) push(32'h100 + i);
    rd_reg(1);
    step(1, 0, 1, 2'd2, 32'h0003_0004, 1, DW'(12'h55));
    rd_reg(1);
    rd_reg(0);
    rd_reg(1);

    // Randomised traffic against the model
    for (int i = 0; i < 500; i++) begin
      bit cs, r, w, sv;
      logic [1:0] a;
      logic [31:0] wd;
      logic [DW-1:0] sd;
      cs = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 2) == 0);
      w  = ($urandom_range(0, 2) == 0);
      a  = 2'($urandom_range(0, 3));
      wd = $urandom;
      if ($urandom_range(0, 7) != 0) wd[17] = 1'b0;
      sv = ($urandom_range(0, 1) == 1);
      sd = DW'($urandom);
      step(cs, r, w, a, wd, sv, sd);
    end

    // Mid-stream asynchronous reset
    wr_reg(1, 32'h000C_0000);
    wr_reg(2, 32'h0001_0003);
    push(7); push(8); push(9);
    rd_reg(2);
    idle();
    async_reset();
    rd_reg(1);
    rd_reg(2);
    idle();

    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
